swc_pck_transfer_output: RTL and testbench

- Output-port end of the page-transfer path; one instance per switch output port.
- Accepts page descriptors (page address, priority) offered by the transfer arbiter and acknowledges each one exactly once.
- Buffers accepted descriptors in a small in-order FIFO.
- Presents them to the output block through a valid/ack handshake.

---
 rtl/swc_pck_transfer_output.sv | 91 +++++++++
 tb/tb_swc_pck_transfer_output.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swc_pck_transfer_output.sv
// Output-port end of the page-transfer path.
// Accepts page descriptors from the transfer arbiter with a one-cycle ack
// pulse, buffers them in a small in-order FIFO and presents the head entry
// to the output block first-word-fall-through with a valid/ack handshake.
module swc_pck_transfer_output #(
    parameter int g_page_addr_width = 10,
    parameter int g_prio_width      = 3,
    parameter int g_fifo_depth      = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            pti_transfer_data_valid_i,
    input  logic [g_page_addr_width-1:0]    pti_pageaddr_i,
    input  logic [g_prio_width-1:0]         pti_prio_i,
    output logic                            pti_transfer_data_ack_o,
    output logic                            ob_transfer_pck_o,
    output logic [g_page_addr_width-1:0]    ob_pageaddr_o,
    output logic [g_prio_width-1:0]         ob_prio_o,
    input  logic                            ob_transfer_ack_i,
    output logic [$clog2(g_fifo_depth):0]   ob_fifo_count_o
);

    localparam int PTR_W = $clog2(g_fifo_depth);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = g_page_addr_width + g_prio_width;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(g_fifo_depth);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [ENT_W-1:0] mem [g_fifo_depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ack;
    logic             push;
    logic             pop;

    // Accept/pop decisions from registered state only; the ack guard stops a
    // second accept of the same descriptor while the arbiter reacts to ack.
    always_comb begin
        push = pti_transfer_data_valid_i & (count != DEPTH_C) & ~ack;
        pop  = ob_transfer_ack_i & (count != '0);
    end

    // Descriptor storage; cleared on reset so the head fields read zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < g_fifo_depth; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {pti_pageaddr_i, pti_prio_i};
        end
    end

    // Pointers wrap modulo depth; count tracks push/pop, unchanged on both.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // One-cycle ack pulse in the cycle after an accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack <= 1'b0;
        end else begin
            ack <= push;
        end
    end

    assign pti_transfer_data_ack_o      = ack;
    assign ob_transfer_pck_o            = (count != '0);
    assign {ob_pageaddr_o, ob_prio_o}   = mem[rd_ptr];
    assign ob_fifo_count_o              = count;

endmodule

// File: tb/tb_swc_pck_transfer_output.sv
// Bench for swc_pck_transfer_output: directed arbiter/output-block stimulus,
// a queue-based reference model checked every cycle, and literal spot checks.
module tb_swc_pck_transfer_output;

    localparam int AW = 10;
    localparam int PW = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] page;
        logic [PW-1:0] prio;
    } desc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [PW-1:0] pr = '0;
    logic          ack;
    logic          pck;
    logic [AW-1:0] ob_pa;
    logic [PW-1:0] ob_pr;
    logic          ob_ack = 1'b0;
    logic [2:0]    cnt;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    swc_pck_transfer_output #(
        .g_page_addr_width(AW),
        .g_prio_width(PW),
        .g_fifo_depth(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .pti_transfer_data_valid_i(valid),
        .pti_pageaddr_i(pa),
        .pti_prio_i(pr),
        .pti_transfer_data_ack_o(ack),
        .ob_transfer_pck_o(pck),
        .ob_pageaddr_o(ob_pa),
        .ob_prio_o(ob_pr),
        .ob_transfer_ack_i(ob_ack),
        .ob_fifo_count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of descriptors plus the pending-ack flag.
    desc_t m_q[$];
    bit    m_ack = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ack = 0;
        end else begin
            bit acc;
            bit pp;
            acc = valid && (m_q.size() != DEPTH) && !m_ack;
            pp  = ob_ack && (m_q.size() != 0);
            if (pp) void'(m_q.pop_front());
            if (acc) m_q.push_back(desc_t'{pa, pr});
            m_ack = acc;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ack", 32'(ack), 32'(m_ack));
            check("model_valid", 32'(pck), 32'(m_q.size() != 0));
            check("model_count", 32'(cnt), 32'(m_q.size()));
            if (m_q.size() != 0) begin
                check("model_page", 32'(ob_pa), 32'(m_q[0].page));
                check("model_prio", 32'(ob_pr), 32'(m_q[0].prio));
            end
        end
    end

    // Record what the DUT hands out on each pop, and peak occupancy.
    desc_t rec[$];
    int    max_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ob_ack && pck) rec.push_back(desc_t'{ob_pa, ob_pr});
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbiter side: hold valid until ack, keep it through the ack cycle.
    task automatic offer(input int page, input int prio);
        int n;
        valid = 1'b1;
        pa = AW'(page);
        pr = PW'(prio);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < 50);
        check("offer_ack_seen", 32'(ack), 32'd1);
        tick();
        valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        ob_ack = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (pck && n < 20);
        ob_ack = 1'b0;
        check("drain_empty", 32'(cnt), 32'd0);
    endtask

    bit stream_done;

    initial begin
        int acks;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        cmp_en = 1;
        #1;
        check("reset_count", 32'(cnt), 32'd0);
        check("reset_valid", 32'(pck), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_page", 32'(ob_pa), 32'd0);
        check("reset_prio", 32'(ob_pr), 32'd0);
        tick();

        // 1. Single transfer
        offer(123, 2);
        check("t1_valid", 32'(pck), 32'd1);
        check("t1_page", 32'(ob_pa), 32'h07B);
        check("t1_prio", 32'(ob_pr), 32'd2);
        tick();
        check("t1_page_held", 32'(ob_pa), 32'h07B);
        ob_ack = 1'b1;
        tick();
        ob_ack = 1'b0;
        check("t1_valid_drop", 32'(pck), 32'd0);
        check("t1_count", 32'(cnt), 32'd0);

        // 2. Fill, blocked offer, release by one pop
        for (int i = 1; i <= 4; i++) offer(i, i - 1);
        check("t2_full", 32'(cnt), 32'd4);
        valid = 1'b1;
        pa = AW'(5);
        pr = PW'(4);
        repeat (3) begin
            tick();
            check("t2_no_ack_full", 32'(ack), 32'd0);
        end
        ob_ack = 1'b1;
        tick();
        ob_ack = 1'b0;
        check("t2_after_pop_ack", 32'(ack), 32'd0);
        check("t2_after_pop_count", 32'(cnt), 32'd3);
        tick();
        check("t2_late_ack", 32'(ack), 32'd1);
        check("t2_refill", 32'(cnt), 32'd4);
        check("t2_head", 32'(ob_pa), 32'd2);
        tick();
        valid = 1'b0;
        drain();

        // 3. Ordered stream with random pops
        rec.delete();
        max_cnt = 0;
        stream_done = 0;
        fork
            begin
                for (int i = 10; i <= 19; i++) offer(i, i % 8);
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    ob_ack = 1'($urandom_range(0, 1));
                    tick();
                end
                ob_ack = 1'b0;
            end
        join
        drain();
        check("t3_popped", 32'(rec.size()), 32'd10);
        for (int i = 0; i < 10 && i < rec.size(); i++) begin
            check("t3_order_page", 32'(rec[i].page), 32'(10 + i));
            check("t3_order_prio", 32'(rec[i].prio), 32'((10 + i) % 8));
        end
        check("t3_max_count", 32'(max_cnt <= DEPTH), 32'd1);

        // 4. Simultaneous push and pop at count 2
        offer(30, 1);
        offer(31, 2);
        check("t4_count2", 32'(cnt), 32'd2);
        valid = 1'b1;
        pa = AW'(32);
        pr = PW'(3);
        ob_ack = 1'b1;
        tick();
        ob_ack = 1'b0;
        check("t4_count_same", 32'(cnt), 32'd2);
        check("t4_head_adv", 32'(ob_pa), 32'd31);
        check("t4_ack", 32'(ack), 32'd1);
        tick();
        valid = 1'b0;
        ob_ack = 1'b1;
        tick();
        ob_ack = 1'b0;
        check("t4_tail_page", 32'(ob_pa), 32'd32);
        check("t4_tail_prio", 32'(ob_pr), 32'd3);
        drain();

        // 5. Spurious pops while empty
        ob_ack = 1'b1;
        repeat (3) tick();
        ob_ack = 1'b0;
        repeat (2) tick();
        check("t5_count", 32'(cnt), 32'd0);
        check("t5_valid", 32'(pck), 32'd0);

        // 6. Reset with buffered data and an ack pending
        offer(40, 0);
        offer(41, 1);
        offer(42, 2);
        check("t6_count3", 32'(cnt), 32'd3);
        valid = 1'b1;
        pa = AW'(10'h055);
        pr = PW'(5);
        tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_count", 32'(cnt), 32'd0);
        check("t6_rst_valid", 32'(pck), 32'd0);
        check("t6_rst_ack", 32'(ack), 32'd0);
        check("t6_rst_page", 32'(ob_pa), 32'd0);
        check("t6_rst_prio", 32'(ob_pr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("t6_rst_no_ack", 32'(ack), 32'd0);
        #1 rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < 10);
        check("t6_reaccept", 32'(ack), 32'd1);
        check("t6_sole_count", 32'(cnt), 32'd1);
        check("t6_sole_page", 32'(ob_pa), 32'h055);
        check("t6_sole_prio", 32'(ob_pr), 32'd5);
        tick();
        valid = 1'b0;
        acks = 0;
        repeat (4) begin
            tick();
            if (ack) acks++;
        end
        check("t6_single_ack", 32'(acks), 32'd0);
        check("t6_count_final", 32'(cnt), 32'd1);
        drain();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
